// File: rtl/maxpool2x2_serp_pkg.sv
// Shared constants, state encoding and width helper for the 2x2 serpentine max-pool stage.
package maxpool2x2_serp_pkg;

  // Conv chip output geometry (defaults for the pooling stage).
  localparam int unsigned CHANNEL_OUT = 32;
  localparam int unsigned OUTPUT_ROW  = 28;
  localparam int unsigned OUTPUT_COL  = 28;
  localparam int unsigned PIX_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    DONE = 2'd3
  } pool_state_e;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool2x2_serp_lane_max.sv
// Lanewise unsigned maximum of two CH x DW vectors (purely combinational).
// Ports: a, b - input vectors, lane c at [(c+1)*DW-1 -: DW]; max_c - lanewise max.
module maxpool2x2_serp_lane_max #(
  parameter int unsigned CH = 32,
  parameter int unsigned DW = 8
) (
  input  logic [CH*DW-1:0] a,
  input  logic [CH*DW-1:0] b,
  output logic [CH*DW-1:0] max_c
);

  for (genvar c = 0; c < CH; c++) begin : g_lane
    assign max_c[(c+1)*DW-1 -: DW] = (a[(c+1)*DW-1 -: DW] >= b[(c+1)*DW-1 -: DW])
                                   ? a[(c+1)*DW-1 -: DW] : b[(c+1)*DW-1 -: DW];
  end

endmodule

// File: rtl/maxpool2x2_serp.sv
// 2x2 stride-2 max pooling over a serpentine-ordered conv output stream.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows
// (traversed right-to-left) combine their pairs with the buffered maxima and
// emit one pooled vector per window.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   frame_start       - one-cycle pulse arming a new frame
//   in_valid, in_data - pixel qualifier and CH x DW pixel vector
//   out_valid         - pooled-pixel strobe; out_data/out_row/out_col qualify it
//   frame_done        - pulses with the last out_valid of a frame
//   err_overrun       - sticky: pixel arrived while IDLE or DONE
module maxpool2x2_serp
  import maxpool2x2_serp_pkg::*;
#(
  parameter int unsigned CH      = CHANNEL_OUT,
  parameter int unsigned DW      = PIX_W,
  parameter int unsigned IMG_ROW = OUTPUT_ROW,
  parameter int unsigned IMG_COL = OUTPUT_COL
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic                             in_valid,
  input  logic [CH*DW-1:0]                 in_data,
  output logic                             out_valid,
  output logic [CH*DW-1:0]                 out_data,
  output logic [idx_w(IMG_ROW/2)-1:0]      out_row,
  output logic [idx_w(IMG_COL/2)-1:0]      out_col,
  output logic                             frame_done,
  output logic                             err_overrun
);

  localparam int unsigned VW       = CH * DW;
  localparam int unsigned HALF_COL = IMG_COL / 2;
  localparam int unsigned COL_W    = idx_w(IMG_COL);
  // One extra bit so row + 2 can reach IMG_ROW without wrapping.
  localparam int unsigned ROW_W    = idx_w(IMG_ROW) + 1;
  localparam int unsigned LB_W     = idx_w(HALF_COL);
  localparam int unsigned OR_W     = idx_w(IMG_ROW / 2);
  localparam int unsigned OC_W     = idx_w(HALF_COL);

  // Geometry sanity: pooling windows must tile the image exactly.
  if ((IMG_ROW == 0) || ((IMG_ROW % 2) != 0)) begin : g_bad_row
    $error("maxpool2x2_serp: IMG_ROW must be a non-zero even number");
  end
  if ((IMG_COL == 0) || ((IMG_COL % 2) != 0)) begin : g_bad_col
    $error("maxpool2x2_serp: IMG_COL must be a non-zero even number");
  end

  pool_state_e             state, state_n, st_e;
  logic [COL_W-1:0]        col, col_n, col_e;
  logic [ROW_W-1:0]        row, row_n, row_e, row_two;
  logic                    phase, phase_n, ph_e;
  logic [VW-1:0]           hold, hold_n;
  logic                    err_n, valid_n, done_n;
  logic [VW-1:0]           data_n;
  logic [OR_W-1:0]         orow_n;
  logic [OC_W-1:0]         ocol_n;

  logic [VW-1:0]           line_buf [HALF_COL];
  logic [LB_W-1:0]         pair_idx;
  logic [VW-1:0]           lb_rd;
  logic                    lb_we;

  logic [VW-1:0]           even_max_c, odd_max_c, final_max_c;

  // Effective context: frame_start rewinds to pixel 0 of EVEN within the same cycle.
  always_comb begin : eff_ctx
    st_e     = frame_start ? EVEN : state;
    col_e    = frame_start ? '0 : col;
    row_e    = frame_start ? '0 : row;
    ph_e     = frame_start ? 1'b0 : phase;
    pair_idx = LB_W'(col_e >> 1);
    lb_rd    = line_buf[pair_idx];
  end

  maxpool2x2_serp_lane_max #(.CH(CH), .DW(DW)) u_even_max (
    .a     (hold),
    .b     (in_data),
    .max_c (even_max_c)
  );

  maxpool2x2_serp_lane_max #(.CH(CH), .DW(DW)) u_odd_max (
    .a     (hold),
    .b     (in_data),
    .max_c (odd_max_c)
  );

  maxpool2x2_serp_lane_max #(.CH(CH), .DW(DW)) u_final_max (
    .a     (lb_rd),
    .b     (odd_max_c),
    .max_c (final_max_c)
  );

  // Next-state and next-output logic.
  always_comb begin : next_logic
    state_n = state;
    col_n   = col;
    row_n   = row;
    phase_n = phase;
    hold_n  = hold;
    err_n   = err_overrun;
    valid_n = 1'b0;
    data_n  = out_data;
    orow_n  = out_row;
    ocol_n  = out_col;
    done_n  = 1'b0;
    lb_we   = 1'b0;
    row_two = row_e + ROW_W'(2);

    if (frame_start) begin
      state_n = EVEN;
      col_n   = '0;
      row_n   = '0;
      phase_n = 1'b0;
      err_n   = 1'b0;
    end

    if (in_valid) begin
      case (st_e)
        EVEN: begin
          phase_n = ~ph_e;
          if (!ph_e) hold_n = in_data;
          else       lb_we  = 1'b1;
          // Last column of an even row: stay on it, the odd row starts here.
          if (col_e == COL_W'(IMG_COL - 1)) state_n = ODD;
          else                              col_n   = col_e + COL_W'(1);
        end
        ODD: begin
          phase_n = ~ph_e;
          if (!ph_e) begin
            hold_n = in_data;
          end else begin
            valid_n = 1'b1;
            data_n  = final_max_c;
            orow_n  = OR_W'(row_e >> 1);
            ocol_n  = OC_W'(col_e >> 1);
          end
          if (col_e == '0) begin
            if (row_two == ROW_W'(IMG_ROW)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else begin
              state_n = EVEN;
              row_n   = row_two;
            end
          end else begin
            col_n = col_e - COL_W'(1);
          end
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      phase       <= 1'b0;
      hold        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row     <= '0;
      out_col     <= '0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      row         <= row_n;
      phase       <= phase_n;
      hold        <= hold_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      out_row     <= orow_n;
      out_col     <= ocol_n;
      frame_done  <= done_n;
      err_overrun <= err_n;
    end
  end

  // Line buffer of even-row pair maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf[pair_idx] <= even_max_c;
  end

endmodule

// File: tb/tb_maxpool2x2_serp.sv
// Randomized self-checking bench for maxpool2x2_serp: a CH=1 and a CH=2
// instance (both 4x4) share stimulus; expectations come from a window-max model.
module tb_maxpool2x2_serp;

  localparam int R = 4;
  localparam int C = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        done;
    logic [31:0] t;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data2 = '0;
  logic [7:0]  in_data1 = '0;

  logic        v1, v2, done1, done2, err1, err2;
  logic [7:0]  d1;
  logic [15:0] d2;
  logic [0:0]  row1, row2, col1, col2;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   stray = 0;
  obs_t q1[$], q2[$], exp_q[$];
  int   drv_t[$];
  logic [15:0] frame [R][C];

  always #5 clk = ~clk;

  maxpool2x2_serp #(.CH(1), .DW(8), .IMG_ROW(R), .IMG_COL(C)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data1), .out_valid(v1), .out_data(d1), .out_row(row1),
    .out_col(col1), .frame_done(done1), .err_overrun(err1)
  );

  maxpool2x2_serp #(.CH(2), .DW(8), .IMG_ROW(R), .IMG_COL(C)) dut2 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data2), .out_valid(v2), .out_data(d2), .out_row(row2),
    .out_col(col2), .frame_done(done2), .err_overrun(err2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every pooled output of both instances with its cycle stamp.
  always @(negedge clk) begin
    obs_t o;
    if (v2) begin
      o = '{d: d2, row: 8'(row2), col: 8'(col2), done: done2, t: 32'(cyc)};
      q2.push_back(o);
    end
    if (v1) begin
      o = '{d: {8'h00, d1}, row: 8'(row1), col: 8'(col1), done: done1, t: 32'(cyc)};
      q1.push_back(o);
    end
    if ((done2 && !v2) || (done1 && !v1)) stray <= stray + 1;
  end

  function automatic string show(input obs_t o);
    return $sformatf("d=%h r=%0d c=%0d done=%b t=%0d", o.d, o.row, o.col, o.done, o.t);
  endfunction

  // Reference: max over each 2x2 window per lane, rows emitted right-to-left;
  // ready one cycle after the second pixel of the odd-row pair is driven.
  function automatic void build_exp();
    obs_t e;
    int   r, idx;
    exp_q.delete();
    for (int pr = 0; pr < R / 2; pr++) begin
      for (int pc = C / 2 - 1; pc >= 0; pc--) begin
        e = '0;
        for (int l = 0; l < 2; l++) begin
          logic [7:0] m;
          m = 8'h00;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              logic [15:0] px;
              px = frame[2*pr+dr][2*pc+dc];
              if (px[8*l +: 8] > m) m = px[8*l +: 8];
            end
          e.d[8*l +: 8] = m;
        end
        e.row  = 8'(pr);
        e.col  = 8'(pc);
        e.done = (pr == R / 2 - 1) && (pc == 0);
        r      = 2 * pr + 1;
        idx    = r * C + (C - 1 - 2 * pc);
        e.t    = (idx < drv_t.size()) ? 32'(drv_t[idx] + 1) : 32'hFFFF_FFFF;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_start = 1'b0;
      in_valid    = 1'b0;
    end
  endtask

  task automatic send_pix(input logic [15:0] d, input logic fs, input int gap);
    @(negedge clk);
    frame_start = fs;
    in_valid    = 1'b1;
    in_data2    = d;
    in_data1    = d[7:0];
    drv_t.push_back(cyc);
    repeat (gap) begin
      @(negedge clk);
      frame_start = 1'b0;
      in_valid    = 1'b0;
      in_data2    = 16'($urandom);
      in_data1    = 8'($urandom);
    end
  endtask

  // Drives the current frame in serpentine order, then lets the pipe drain.
  task automatic drive_frame(input int gapmax, input logic fs_first);
    q1.delete(); q2.delete(); drv_t.delete();
    if (!fs_first) begin
      @(negedge clk);
      frame_start = 1'b1;
      in_valid    = 1'b0;
    end
    for (int r = 0; r < R; r++)
      for (int k = 0; k < C; k++) begin
        int c;
        c = (r % 2 == 0) ? k : C - 1 - k;
        send_pix(frame[r][c], fs_first && (r == 0) && (k == 0), $urandom_range(gapmax, 0));
      end
    idle(4);
  endtask

  task automatic ramp_frame(input logic inv_lane1);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        logic [7:0] v;
        v = 8'(4 * r + c);
        frame[r][c] = {inv_lane1 ? 8'(255 - v) : 8'h00, v};
      end
  endtask

  task automatic rand_frame();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) frame[r][c] = 16'($urandom);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({v2, d2, row2, col2, done2, err2} !== '0) begin
      miscompares++; $display("FAIL reset_state dut2: got %h want 0", {v2, d2, row2, col2, done2, err2});
    end
    q1.delete(); q2.delete();
    send_pix(16'h1234, 1'b0, 0);
    idle(1);
    vectors++;
    if (err2 !== 1'b1 || err1 !== 1'b1 || q2.size() != 0 || q1.size() != 0) begin
      miscompares++; $display("FAIL overrun_idle: err2=%b err1=%b outs=%0d want err=1 outs=0", err2, err1, q2.size());
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({v2, d2, row2, col2, done2, err2} !== '0 || {v1, d1, row1, col1, done1, err1} !== '0) begin
      miscompares++; $display("FAIL async_reset: dut2 %h dut1 %h want 0", {v2, d2, row2, col2, done2, err2}, {v1, d1, row1, col1, done1, err1});
    end
    @(negedge clk);
    rst = 1'b0;
    send_pix(16'h00AA, 1'b0, 0);
    idle(2);
    vectors++;
    if (err2 !== 1'b1 || q2.size() != 0) begin
      miscompares++; $display("FAIL overrun_after_reset: err2=%b outs=%0d want err=1 outs=0", err2, q2.size());
    end
  endtask

  task automatic test_ramp_single_lane();
    logic [7:0] want_d [4];
    logic [7:0] want_c [4];
    logic [7:0] want_r [4];
    obs_t w;
    want_d = '{8'd7, 8'd5, 8'd15, 8'd13};
    want_c = '{8'd1, 8'd0, 8'd1, 8'd0};
    want_r = '{8'd0, 8'd0, 8'd1, 8'd1};
    ramp_frame(1'b0);
    drive_frame(0, 1'b0);
    build_exp();
    vectors++;
    if (q1.size() != 4) begin
      miscompares++; $display("FAIL ramp_count: got %0d outputs want 4", q1.size());
    end
    for (int i = 0; i < 4 && i < q1.size(); i++) begin
      w = '{d: {8'h00, want_d[i]}, row: want_r[i], col: want_c[i], done: (i == 3), t: exp_q[i].t};
      vectors++;
      if (q1[i] !== w) begin
        miscompares++; $display("FAIL ramp_out%0d: got %s want %s", i, show(q1[i]), show(w));
      end
    end
  endtask

  task automatic test_lane_independence();
    ramp_frame(1'b1);
    drive_frame(0, 1'b0);
    build_exp();
    vectors++;
    if (q2.size() != exp_q.size()) begin
      miscompares++; $display("FAIL lanes_count: got %0d want %0d", q2.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q2.size(); i++) begin
      vectors++;
      if (q2[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL lanes_out%0d: got %s want %s", i, show(q2[i]), show(exp_q[i]));
      end
    end
  endtask

  task automatic test_gaps();
    ramp_frame(1'b0);
    drive_frame(3, 1'b0);
    build_exp();
    vectors++;
    if (q2.size() != exp_q.size()) begin
      miscompares++; $display("FAIL gaps_count: got %0d want %0d", q2.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q2.size(); i++) begin
      vectors++;
      if (q2[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL gaps_out%0d: got %s want %s", i, show(q2[i]), show(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 6; i++) send_pix(16'hFFFF, i == 0, 0);
    idle(1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    q1.delete(); q2.delete();
    idle(3);
    vectors++;
    if (q2.size() != 0 || err2 !== 1'b0) begin
      miscompares++; $display("FAIL midreset_quiet: outs=%0d err=%b want 0 0", q2.size(), err2);
    end
    ramp_frame(1'b0);
    drive_frame(1, 1'b0);
    build_exp();
    vectors++;
    if (q2.size() != 4) begin
      miscompares++; $display("FAIL midreset_count: got %0d want 4", q2.size());
    end
    for (int i = 0; i < exp_q.size() && i < q2.size(); i++) begin
      vectors++;
      if (q2[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL midreset_out%0d: got %s want %s", i, show(q2[i]), show(exp_q[i]));
      end
    end
  endtask

  task automatic test_overrun_restart();
    q1.delete(); q2.delete();
    send_pix(16'h5A5A, 1'b0, 0);
    idle(2);
    vectors++;
    if (err2 !== 1'b1 || q2.size() != 0) begin
      miscompares++; $display("FAIL overrun_done: err=%b outs=%0d want 1 0", err2, q2.size());
    end
    rand_frame();
    drive_frame(2, 1'b1);
    build_exp();
    vectors++;
    if (err2 !== 1'b0 || q2.size() != exp_q.size()) begin
      miscompares++; $display("FAIL restart_state: err=%b outs=%0d want 0 %0d", err2, q2.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q2.size(); i++) begin
      vectors++;
      if (q2[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL restart_out%0d: got %s want %s", i, show(q2[i]), show(exp_q[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      drive_frame(f % 3, 1'($urandom_range(1, 0)));
      build_exp();
      vectors++;
      if (q2.size() != exp_q.size() || q1.size() != exp_q.size()) begin
        miscompares++; $display("FAIL b2b%0d_count: got %0d/%0d want %0d", f, q2.size(), q1.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < q2.size() && i < q1.size(); i++) begin
        obs_t w1;
        w1 = exp_q[i];
        w1.d[15:8] = 8'h00;
        vectors++;
        if (q2[i] !== exp_q[i] || q1[i] !== w1) begin
          miscompares++; $display("FAIL b2b%0d_out%0d: got %s / %s want %s", f, i, show(q2[i]), show(q1[i]), show(exp_q[i]));
        end
      end
    end
    vectors++;
    if (stray != 0) begin
      miscompares++; $display("FAIL stray_frame_done: got %0d want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_single_lane();
    test_lane_independence();
    test_gaps();
    test_reset_mid_frame();
    test_overrun_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
